// File: rtl/uart_tx_feeder_pkg.sv
// uart_tx_feeder_pkg: definitions shared by the uart_tx feeder and its FIFO.
//   - feeder FSM state encoding (3-bit)
//   - default byte width
//   - clog2() for sizing pointers and counters from parameters
package uart_tx_feeder_pkg;

  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } feeder_state_e;

  // Bits needed to count 0..value-1 (returns 0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_feeder_sync_fifo.sv
// sync_fifo: single-clock FIFO holding bytes for the uart_tx feeder.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_push/i_data   enqueue request and byte (dropped when full or flushing)
//   i_pop           dequeue request (ignored when empty or flushing)
//   i_flush         clear contents; beats push and pop in the same cycle
//   o_head          byte at the read pointer, straight from storage registers
//   o_full/o_empty  level decode
//   o_level         entries held, 0..DEPTH
module sync_fifo
  import uart_tx_feeder_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int DEPTH      = 16,
  localparam int ADDR_W     = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  input  logic                  i_flush,
  output logic [DATA_WIDTH-1:0] o_head,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [ADDR_W:0]       o_level
);

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0]     r_wr_ptr;
  logic [ADDR_W-1:0]     r_rd_ptr;
  logic [ADDR_W:0]       r_level;
  logic                  w_push_ok;
  logic                  w_pop_ok;

  assign o_full    = (r_level == FULL_LVL);
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_head    = r_mem[r_rd_ptr];

  // Full/empty come from the level before this cycle's traffic, so a push
  // into a full FIFO is dropped even if a pop frees a slot in the same cycle.
  assign w_push_ok = i_push && !o_full  && !i_flush;
  assign w_pop_ok  = i_pop  && !o_empty && !i_flush;

  // Storage needs no reset: nothing is read before it has been written.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      if (w_push_ok && !w_pop_ok)      r_level <= r_level + (ADDR_W+1)'(1);
      else if (w_pop_ok && !w_push_ok) r_level <= r_level - (ADDR_W+1)'(1);
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers host bytes and hands them one at a time to uart_tx
// over the tx_data/tx_start -> data_ack/tx_busy handshake.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   wr_en, wr_data           host push into the FIFO
//   enable                   allows new transfers (never aborts one in flight)
//   flush                    one-cycle FIFO clear
//   err_clr                  clears overflow and ack_timeout
//   fifo_full/empty/level    FIFO status
//   tx_data, tx_start        byte and one-cycle start pulse to uart_tx
//   tx_busy, data_ack        status from uart_tx
//   overflow                 sticky: push attempted while full
//   ack_timeout              sticky: no data_ack within ACK_TIMEOUT cycles
//   idle                     FSM idle and FIFO empty
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter  int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter  int DEPTH       = 16,
  parameter  int ACK_TIMEOUT = 64,
  localparam int ADDR_W      = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  err_clr,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic [ADDR_W:0]       fifo_level,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  input  logic                  data_ack,
  output logic                  overflow,
  output logic                  ack_timeout,
  output logic                  idle
);

  localparam int            CNT_W    = clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  feeder_state_e         r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_tx_data, w_tx_data_nxt;
  logic                  r_tx_start, w_tx_start_nxt;
  logic                  r_overflow, r_ack_timeout;
  logic                  w_pop;
  logic                  w_timeout;
  logic                  w_ovf_set;
  logic [DATA_WIDTH-1:0] w_head;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (wr_en),
    .i_data  (wr_data),
    .i_pop   (w_pop),
    .i_flush (flush),
    .o_head  (w_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_start <= w_tx_start_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_tx_data_nxt  = r_tx_data;
    w_tx_start_nxt = 1'b0;
    w_pop          = 1'b0;
    w_timeout      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable && !fifo_empty && !tx_busy && !flush) begin
          w_tx_data_nxt  = w_head;
          w_tx_start_nxt = 1'b1;
          w_state_nxt    = ST_START;
        end
      end
      // START accepts an early ack exactly like WAIT_ACK. The counter holds
      // the number of WAIT_ACK cycles elapsed, so the abort lands on the
      // ACK_TIMEOUT-th cycle counted from the start pulse.
      ST_START, ST_WAIT_ACK: begin
        w_cnt_nxt = (r_state == ST_START) ? '0 : r_cnt + CNT_W'(1);
        if (flush) begin
          w_state_nxt = ST_IDLE;
        end else if (data_ack) begin
          w_pop       = 1'b1;
          w_state_nxt = tx_busy ? ST_WAIT_IDLE : ST_WAIT_BUSY;
        end else if (r_state == ST_WAIT_ACK && w_cnt_nxt == CNT_LAST) begin
          // Head stays queued so the byte is retried from IDLE.
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_state == ST_START) begin
          w_state_nxt = ST_WAIT_ACK;
        end
      end
      // Byte is committed once acked; flush no longer matters here.
      ST_WAIT_BUSY: if (tx_busy)  w_state_nxt = ST_WAIT_IDLE;
      ST_WAIT_IDLE: if (!tx_busy) w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  // A flush drops a same-cycle write silently, so it never counts as overflow.
  assign w_ovf_set = wr_en && fifo_full && !flush;

  // A new error in the clearing cycle wins over err_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow    <= 1'b0;
      r_ack_timeout <= 1'b0;
    end else begin
      r_overflow    <= w_ovf_set || (r_overflow    && !err_clr);
      r_ack_timeout <= w_timeout || (r_ack_timeout && !err_clr);
    end
  end

  assign tx_data     = r_tx_data;
  assign tx_start    = r_tx_start;
  assign overflow    = r_overflow;
  assign ack_timeout = r_ack_timeout;
  assign idle        = (r_state == ST_IDLE) && fifo_empty;

endmodule
